sdram_port_arbiter: RTL and testbench

SDRAM_PORT_ARBITER -- requirements
Module: sdram_port_arbiter

---
 rtl/sdram_port_arbiter.sv | 111 +++++++++++
 tb/tb_sdram_port_arbiter.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: two-port (video/CPU) arbiter in front of a single-outstanding SDRAM controller; define ARB_STARVE_EN to enable CPU anti-starvation
module sdram_port_arbiter #(
  parameter int ADDR_W = 24,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset_n_i,
  input  logic              vid_req_i,
  input  logic              vid_we_i,
  input  logic [ADDR_W-1:0] vid_addr_i,
  input  logic [31:0]       vid_wdata_i,
  input  logic [3:0]        vid_wmask_i,
  output logic              vid_ack_o,
  output logic [31:0]       vid_rdata_o,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [31:0]       cpu_wdata_i,
  input  logic [3:0]        cpu_wmask_i,
  output logic              cpu_ack_o,
  output logic [31:0]       cpu_rdata_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  output logic [3:0]        mem_wmask_o,
  input  logic              mem_ready_i,
  input  logic              mem_rvalid_i,
  input  logic [31:0]       mem_rdata_i,
  output logic              busy_o
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, DONE} state_t;
  state_t state, state_nx;
  logic grant;
  logic pick_cpu;
  logic arb;
  logic req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0] req_wmask;
  logic [31:0] vid_rdata, cpu_rdata;

  if (STARVE_MAX < 1) begin : g_bad_starve_max
    $error("STARVE_MAX must be at least 1");
  end

  assign arb = (state == IDLE) && (vid_req_i || cpu_req_i);

`ifdef ARB_STARVE_EN
  localparam int CW = $clog2(STARVE_MAX + 1);
  logic [CW-1:0] starve_cnt;
  assign pick_cpu = cpu_req_i && (!vid_req_i || starve_cnt == CW'(STARVE_MAX));
  // count video grants that bypass a waiting CPU; a CPU grant starts over
  always_ff @(posedge clk)
    if (!reset_n_i) starve_cnt <= '0;
    else if (arb) starve_cnt <= pick_cpu ? '0 : (cpu_req_i && starve_cnt != CW'(STARVE_MAX)) ? starve_cnt + CW'(1) : starve_cnt;
`else
  assign pick_cpu = cpu_req_i && !vid_req_i;
`endif

  // state register
  always_ff @(posedge clk) state <= !reset_n_i ? IDLE : state_nx;

  // next state: one transaction at a time, reads wait for the return beat
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = (vid_req_i || cpu_req_i) ? ISSUE : IDLE;
      ISSUE:   state_nx = mem_ready_i ? (req_we ? DONE : WAIT_RD) : ISSUE;
      WAIT_RD: state_nx = mem_rvalid_i ? DONE : WAIT_RD;
      default: state_nx = IDLE;
    endcase
  end

  // latch the winner's command so later requester changes cannot disturb it
  always_ff @(posedge clk)
    if (!reset_n_i) begin
      grant     <= 1'b0;
      req_we    <= 1'b0;
      req_addr  <= '0;
      req_wdata <= '0;
      req_wmask <= '0;
    end else if (arb) begin
      grant     <= pick_cpu;
      req_we    <= pick_cpu ? cpu_we_i : vid_we_i;
      req_addr  <= pick_cpu ? cpu_addr_i : vid_addr_i;
      req_wdata <= pick_cpu ? cpu_wdata_i : vid_wdata_i;
      req_wmask <= pick_cpu ? cpu_wmask_i : vid_wmask_i;
    end

  // read return lands only in the granted port's register, only while waiting for it
  always_ff @(posedge clk)
    if (!reset_n_i) begin
      vid_rdata <= '0;
      cpu_rdata <= '0;
    end else if (state == WAIT_RD && mem_rvalid_i) begin
      if (grant) cpu_rdata <= mem_rdata_i;
      else vid_rdata <= mem_rdata_i;
    end

  assign mem_req_o   = state == ISSUE;
  assign mem_we_o    = req_we;
  assign mem_addr_o  = req_addr;
  assign mem_wdata_o = req_wdata;
  assign mem_wmask_o = req_wmask;
  assign vid_ack_o   = (state == DONE) && !grant;
  assign cpu_ack_o   = (state == DONE) && grant;
  assign vid_rdata_o = vid_rdata;
  assign cpu_rdata_o = cpu_rdata;
  assign busy_o      = state != IDLE;
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb_sdram_port_arbiter: randomized self-checking bench with a memory responder and a transaction-level arbitration model
module tb_sdram_port_arbiter;
  localparam int AW = 24;
  localparam int SMAX = 4;
`ifdef ARB_STARVE_EN
  localparam bit STARVE_EN = 1'b1;
`else
  localparam bit STARVE_EN = 1'b0;
`endif

  typedef struct packed {
    logic we;
    logic [AW-1:0] a;
    logic [31:0] d;
    logic [3:0] m;
  } cmd_t;

  logic clk = 1'b0;
  logic reset_n_i = 1'b0;
  logic vid_req_i = 1'b0, vid_we_i = 1'b0, cpu_req_i = 1'b0, cpu_we_i = 1'b0;
  logic [AW-1:0] vid_addr_i = '0, cpu_addr_i = '0;
  logic [31:0] vid_wdata_i = '0, cpu_wdata_i = '0;
  logic [3:0] vid_wmask_i = '0, cpu_wmask_i = '0;
  logic vid_ack_o, cpu_ack_o, mem_req_o, mem_we_o, busy_o;
  logic [31:0] vid_rdata_o, cpu_rdata_o, mem_wdata_o;
  logic [AW-1:0] mem_addr_o;
  logic [3:0] mem_wmask_o;
  logic mem_ready_i = 1'b1, mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;

  int pass_n = 0, chk_n = 0;
  int vid_acks = 0, cpu_acks = 0, both_acks = 0, req_cycles = 0;
  cmd_t acc_log [512];
  int acc_n = 0;
  logic acc_now = 1'b0, acc_we = 1'b0;
  logic [AW-1:0] acc_a = '0;
  int rd_delay = 1, rd_left = 0;
  int model_cnt = 0;

  always #5 clk = ~clk;

  sdram_port_arbiter #(.ADDR_W(AW), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .reset_n_i(reset_n_i),
    .vid_req_i(vid_req_i), .vid_we_i(vid_we_i), .vid_addr_i(vid_addr_i), .vid_wdata_i(vid_wdata_i),
    .vid_wmask_i(vid_wmask_i), .vid_ack_o(vid_ack_o), .vid_rdata_o(vid_rdata_o),
    .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i), .cpu_wdata_i(cpu_wdata_i),
    .cpu_wmask_i(cpu_wmask_i), .cpu_ack_o(cpu_ack_o), .cpu_rdata_o(cpu_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_wmask_o(mem_wmask_o), .mem_ready_i(mem_ready_i), .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i(mem_rdata_i), .busy_o(busy_o)
  );

  function automatic logic [31:0] rdfn(input logic [AW-1:0] a);
    return 32'h12345678 ^ {{(32 - AW){1'b0}}, a};
  endfunction

  function automatic cmd_t mk(input logic we, input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] m);
    cmd_t c;
    c.we = we; c.a = a; c.d = d; c.m = m;
    return c;
  endfunction

  // mid-cycle monitor: acceptances, ack pulses, request cycles
  always @(negedge clk) begin
    acc_now = mem_req_o && mem_ready_i;
    acc_we = mem_we_o;
    acc_a = mem_addr_o;
    if (acc_now && acc_n < 512) begin
      acc_log[acc_n] = mk(mem_we_o, mem_addr_o, mem_wdata_o, mem_wmask_o);
      acc_n++;
    end
    if (mem_req_o) req_cycles++;
    if (vid_ack_o) vid_acks++;
    if (cpu_ack_o) cpu_acks++;
    if (vid_ack_o && cpu_ack_o) both_acks++;
  end

  // memory responder: read data returns rd_delay cycles after acceptance
  always @(posedge clk) begin
    #1;
    if (acc_now && !acc_we) begin
      rd_left = rd_delay;
      mem_rdata_i = rdfn(acc_a);
    end else if (rd_left > 0) rd_left--;
    mem_rvalid_i = (rd_left == 1);
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic vid_txn(input cmd_t c, output logic [31:0] rd, output int lat);
    vid_we_i = c.we; vid_addr_i = c.a; vid_wdata_i = c.d; vid_wmask_i = c.m; vid_req_i = 1'b1;
    lat = 0; rd = '0;
    for (int n = 1; n <= 80 && lat == 0; n++) begin
      @(negedge clk);
      if (vid_ack_o) begin lat = n; rd = vid_rdata_o; end
    end
    @(posedge clk); #1;
    vid_req_i = 1'b0;
  endtask

  task automatic cpu_txn(input cmd_t c, output logic [31:0] rd, output int lat);
    cpu_we_i = c.we; cpu_addr_i = c.a; cpu_wdata_i = c.d; cpu_wmask_i = c.m; cpu_req_i = 1'b1;
    lat = 0; rd = '0;
    for (int n = 1; n <= 80 && lat == 0; n++) begin
      @(negedge clk);
      if (cpu_ack_o) begin lat = n; rd = cpu_rdata_o; end
    end
    @(posedge clk); #1;
    cpu_req_i = 1'b0;
  endtask

  // one arbitration round: both requests rise together; the model predicts order, latency and data
  task automatic do_round(input bit v_on, input bit c_on, input cmd_t vc, input cmd_t cc, input string tag);
    int p, va0, ca0, ba0, lv, lc, sv, sc, ev, ec;
    logic [31:0] rv, rc;
    bit cpu_first;
    cmd_t first, second;
    p = acc_n; va0 = vid_acks; ca0 = cpu_acks; ba0 = both_acks;
    cpu_first = c_on && (!v_on || (STARVE_EN && model_cnt == SMAX));
    sv = vc.we ? 3 : 3 + rd_delay;
    sc = cc.we ? 3 : 3 + rd_delay;
    ev = (v_on && c_on && cpu_first) ? sc + sv : sv;
    ec = (v_on && c_on && !cpu_first) ? sv + sc : sc;
    if (c_on) model_cnt = 0;
    fork
      if (v_on) vid_txn(vc, rv, lv);
      if (c_on) cpu_txn(cc, rc, lc);
    join
    first = cpu_first ? cc : vc;
    second = cpu_first ? vc : cc;
    chk_n++; if (acc_n - p !== int'(v_on) + int'(c_on)) $display("FAIL %s accept_count: got %0d want %0d", tag, acc_n - p, int'(v_on) + int'(c_on)); else pass_n++;
    if (v_on) begin
      chk_n++; if (lv !== ev) $display("FAIL %s vid_latency: got %0d want %0d", tag, lv, ev); else pass_n++;
      if (!vc.we) begin
        chk_n++; if (rv !== rdfn(vc.a)) $display("FAIL %s vid_rdata: got %h want %h", tag, rv, rdfn(vc.a)); else pass_n++;
      end
    end
    if (c_on) begin
      chk_n++; if (lc !== ec) $display("FAIL %s cpu_latency: got %0d want %0d", tag, lc, ec); else pass_n++;
      if (!cc.we) begin
        chk_n++; if (rc !== rdfn(cc.a)) $display("FAIL %s cpu_rdata: got %h want %h", tag, rc, rdfn(cc.a)); else pass_n++;
      end
    end
    chk_n++; if (acc_log[p] !== first) $display("FAIL %s first_cmd: got %h want %h", tag, acc_log[p], first); else pass_n++;
    if (v_on && c_on) begin
      chk_n++; if (acc_log[p+1] !== second) $display("FAIL %s second_cmd: got %h want %h", tag, acc_log[p+1], second); else pass_n++;
    end
    chk_n++; if (vid_acks - va0 !== int'(v_on)) $display("FAIL %s vid_ack_count: got %0d want %0d", tag, vid_acks - va0, int'(v_on)); else pass_n++;
    chk_n++; if (cpu_acks - ca0 !== int'(c_on)) $display("FAIL %s cpu_ack_count: got %0d want %0d", tag, cpu_acks - ca0, int'(c_on)); else pass_n++;
    chk_n++; if (both_acks - ba0 !== 0) $display("FAIL %s dual_ack: got %0d want 0", tag, both_acks - ba0); else pass_n++;
  endtask

  task automatic test_reset;
    reset_n_i = 1'b0; vid_req_i = 1'b1; cpu_req_i = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_n++; if (busy_o !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy_o); else pass_n++;
    chk_n++; if (mem_req_o !== 1'b0) $display("FAIL reset_mem_req: got %b want 0", mem_req_o); else pass_n++;
    chk_n++; if (vid_ack_o !== 1'b0 || cpu_ack_o !== 1'b0) $display("FAIL reset_acks: got %b%b want 00", vid_ack_o, cpu_ack_o); else pass_n++;
    chk_n++; if (vid_rdata_o !== 32'h0 || cpu_rdata_o !== 32'h0) $display("FAIL reset_rdata: got %h %h want 0", vid_rdata_o, cpu_rdata_o); else pass_n++;
    chk_n++; if (mem_addr_o !== '0 || mem_wdata_o !== 32'h0 || mem_wmask_o !== 4'h0 || mem_we_o !== 1'b0) $display("FAIL reset_fields: got %b %h %h %h want 0", mem_we_o, mem_addr_o, mem_wdata_o, mem_wmask_o); else pass_n++;
    @(posedge clk); #1;
    reset_n_i = 1'b1; vid_req_i = 1'b0; cpu_req_i = 1'b0;
    @(negedge clk);
    chk_n++; if (busy_o !== 1'b0) $display("FAIL post_reset_idle: got %b want 0", busy_o); else pass_n++;
    @(posedge clk); #1;
    model_cnt = 0;
  endtask

  task automatic test_cpu_write;
    int r0;
    r0 = req_cycles;
    do_round(1'b0, 1'b1, mk(1'b0, 24'h0, 32'h0, 4'h0), mk(1'b1, 24'h000010, 32'hDEADBEEF, 4'hF), "cpu_write");
    chk_n++; if (req_cycles - r0 !== 1) $display("FAIL cpu_write mem_req_cycles: got %0d want 1", req_cycles - r0); else pass_n++;
  endtask

  task automatic test_vid_read;
    rd_delay = 5;
    do_round(1'b1, 1'b0, mk(1'b0, 24'h000000, $urandom, 4'($urandom)), mk(1'b0, 24'h0, 32'h0, 4'h0), "vid_read");
    chk_n++; if (vid_rdata_o !== 32'h12345678) $display("FAIL vid_read held_rdata: got %h want 12345678", vid_rdata_o); else pass_n++;
    rd_delay = 1;
  endtask

  task automatic test_simultaneous;
    do_round(1'b1, 1'b1, mk(1'b0, 24'h000100, 32'h0, 4'h0), mk(1'b0, 24'h000201, 32'h0, 4'h0), "simul_read");
  endtask

  task automatic test_ready_stall;
    int r0, p, lat, w;
    bit stable;
    logic [31:0] rd;
    cmd_t c;
    c = mk(1'b1, 24'h0ABCDE, 32'hCAFEF00D, 4'h5);
    r0 = req_cycles; p = acc_n; stable = 1'b1;
    mem_ready_i = 1'b0;
    fork
      cpu_txn(c, rd, lat);
      begin
        w = 0;
        do begin @(negedge clk); w++; end while (!mem_req_o && w < 20);
        for (int k = 0; k < 7; k++) begin
          if (k > 0) @(negedge clk);
          if (mem_req_o !== 1'b1 || mk(mem_we_o, mem_addr_o, mem_wdata_o, mem_wmask_o) !== c) stable = 1'b0;
        end
        @(posedge clk); #1;
        mem_ready_i = 1'b1;
        @(negedge clk);
        if (mem_req_o !== 1'b1 || mk(mem_we_o, mem_addr_o, mem_wdata_o, mem_wmask_o) !== c) stable = 1'b0;
      end
    join
    model_cnt = 0;
    chk_n++; if (stable !== 1'b1) $display("FAIL stall fields_stable: got %b want 1", stable); else pass_n++;
    chk_n++; if (req_cycles - r0 !== 8) $display("FAIL stall mem_req_cycles: got %0d want 8", req_cycles - r0); else pass_n++;
    chk_n++; if (acc_n - p !== 1) $display("FAIL stall accept_count: got %0d want 1", acc_n - p); else pass_n++;
    chk_n++; if (lat !== 10) $display("FAIL stall cpu_latency: got %0d want 10", lat); else pass_n++;
  endtask

  task automatic test_starve;
    int vseen, g, cnt;
    bit cseen;
    cnt = model_cnt; g = 0;
    while (!(STARVE_EN && cnt == SMAX) && g < 10) begin
      g++;
      if (cnt < SMAX) cnt++;
    end
    vid_we_i = 1'b0; vid_addr_i = 24'h000300; vid_req_i = 1'b1;
    cpu_we_i = 1'b1; cpu_addr_i = 24'h000401; cpu_wdata_i = 32'h0BADF00D; cpu_wmask_i = 4'hC; cpu_req_i = 1'b1;
    vseen = 0; cseen = 1'b0;
    for (int n = 0; n < 400 && !cseen && vseen < 10; n++) begin
      @(negedge clk);
      if (vid_ack_o) vseen++;
      if (cpu_ack_o) cseen = 1'b1;
    end
    @(posedge clk); #1;
    vid_req_i = 1'b0; cpu_req_i = 1'b0;
    model_cnt = 0;
    chk_n++; if (vseen !== g) $display("FAIL starve vid_grants_before_cpu: got %0d want %0d", vseen, g); else pass_n++;
    chk_n++; if (cseen !== STARVE_EN) $display("FAIL starve cpu_granted: got %b want %b", cseen, STARVE_EN); else pass_n++;
    @(negedge clk);
    chk_n++; if (busy_o !== 1'b0) $display("FAIL starve idle_after: got %b want 0", busy_o); else pass_n++;
    @(posedge clk); #1;
  endtask

  task automatic test_random;
    bit v_on, c_on;
    cmd_t vc, cc;
    for (int i = 0; i < 30; i++) begin
      v_on = 1'($urandom);
      c_on = !v_on || 1'($urandom);
      rd_delay = $urandom_range(1, 4);
      vc = mk(1'($urandom), AW'($urandom) & ~AW'(1), $urandom, 4'($urandom));
      cc = mk(1'($urandom), AW'($urandom) | AW'(1), $urandom, 4'($urandom));
      do_round(v_on, c_on, vc, cc, $sformatf("rand%0d", i));
    end
    rd_delay = 1;
  endtask

  task automatic test_reset_mid;
    int va0, ca0, r0, w;
    bit busy_seen;
    rd_delay = 12; va0 = vid_acks; ca0 = cpu_acks; r0 = req_cycles; busy_seen = 1'b0;
    vid_we_i = 1'b0; vid_addr_i = 24'h000100; vid_req_i = 1'b1;
    w = 0;
    do begin @(negedge clk); w++; end while (!mem_req_o && w < 20);
    chk_n++; if (mem_req_o !== 1'b1) $display("FAIL reset_mid issue_seen: got %b want 1", mem_req_o); else pass_n++;
    @(posedge clk); #1;
    reset_n_i = 1'b0; vid_req_i = 1'b0;
    @(posedge clk); #1;
    reset_n_i = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (busy_o) busy_seen = 1'b1;
    end
    @(posedge clk); #1;
    model_cnt = 0;
    chk_n++; if (vid_acks - va0 !== 0 || cpu_acks - ca0 !== 0) $display("FAIL reset_mid acks: got %0d %0d want 0 0", vid_acks - va0, cpu_acks - ca0); else pass_n++;
    chk_n++; if (busy_seen !== 1'b0) $display("FAIL reset_mid busy_after_release: got %b want 0", busy_seen); else pass_n++;
    chk_n++; if (req_cycles - r0 !== 1) $display("FAIL reset_mid mem_req_cycles: got %0d want 1", req_cycles - r0); else pass_n++;
    chk_n++; if (vid_rdata_o !== 32'h0) $display("FAIL reset_mid stray_rdata: got %h want 0", vid_rdata_o); else pass_n++;
    rd_delay = 1;
  endtask

  initial begin
    test_reset();
    test_cpu_write();
    test_vid_read();
    test_simultaneous();
    test_ready_stall();
    test_starve();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_n, chk_n);
    $finish;
  end
endmodule
